// File: rtl/kbd_fifo_if.sv
// kbd_fifo_if: producer/consumer bundle for kbd_fifo.
// master drives flush/write/read requests; slave is the FIFO returning data and flags.
interface kbd_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
);
  logic                  clr;
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_en;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/kbd_fifo.sv
// kbd_fifo: single-clock byte FIFO with count, sticky overflow and drop/overwrite policy.
// Ports: clk, rst (sync, active-high), bus (kbd_fifo_if.slave: clr, wr/rd requests, data, flags).
module kbd_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  kbd_fifo_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [WIDTH-1:0]      rdat_q, rdat_d;
  logic                  rval_q, rval_d;

  logic rd_ok;
  logic wr_ok;
  logic wr_mem;
  logic is_full;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rdat_d  = '0;
    rval_d  = 1'b0;
    wr_mem  = 1'b0;
    is_full = (cnt_q == DEPTH_C);
    rd_ok   = bus.rd_en && (cnt_q != '0);
    // a read in the same cycle frees a slot, so a full FIFO still accepts
    wr_ok   = bus.wr_en && (!is_full || rd_ok);

    if (bus.clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      rd_ok  = 1'b0;
      wr_ok  = 1'b0;
    end else begin
      if (rd_ok) begin
        rval_d = 1'b1;
        rdat_d = mem_q[head_q];
        head_d = head_q + 1'b1;
      end
      if (wr_ok) begin
        wr_mem = 1'b1;
        tail_d = tail_q + 1'b1;
      end else if (bus.wr_en) begin
        ovf_d = 1'b1;
        if (OVERWRITE) begin
          // ring stays full: oldest word is pushed out by the new one
          wr_mem = 1'b1;
          tail_d = tail_q + 1'b1;
          head_d = head_q + 1'b1;
        end
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      rdat_q <= '0;
      rval_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rdat_q <= rdat_d;
      rval_q <= rval_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_mem) begin
      mem_q[tail_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = rdat_q;
  assign bus.rd_valid = rval_q;
  assign bus.count    = cnt_q;
  assign bus.empty    = (cnt_q == '0);
  assign bus.full     = is_full;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: drives a drop-new and an overwrite-oldest kbd_fifo with the same stimulus.
// A queue model per instance is checked every cycle, plus literal expectations.
module tb_kbd_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  bit         run = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    kbd_fifo_if #(.WIDTH(8), .DEPTH_LOG2(5)) bus ();

    assign bus.clr     = clr;
    assign bus.wr_en   = wr_en;
    assign bus.wr_data = wr_data;
    assign bus.rd_en   = rd_en;

    kbd_fifo #(.WIDTH(8), .DEPTH_LOG2(5), .OVERWRITE(g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    logic [7:0] q[$];
    logic [7:0] ed = '0;
    bit         ev = 1'b0;
    bit         ovf = 1'b0;

    always @(posedge clk) begin
      if (rst || clr) begin
        q.delete();
        ovf = 1'b0;
        ev  = 1'b0;
        ed  = '0;
      end else begin
        if (rd_en && q.size() != 0) begin
          ed = q.pop_front();
          ev = 1'b1;
        end else begin
          ed = '0;
          ev = 1'b0;
        end
        if (wr_en) begin
          if (q.size() < 32) begin
            q.push_back(wr_data);
          end else begin
            ovf = 1'b1;
            if (g == 1) begin
              void'(q.pop_front());
              q.push_back(wr_data);
            end
          end
        end
      end
    end

    always @(negedge clk) begin
      if (run) begin
        chk($sformatf("rd_valid[%0d]", g), 32'(bus.rd_valid), 32'(ev));
        chk($sformatf("rd_data[%0d]", g), 32'(bus.rd_data), 32'(ed));
        chk($sformatf("count[%0d]", g), 32'(bus.count), q.size());
        chk($sformatf("empty[%0d]", g), 32'(bus.empty), 32'(q.size() == 0));
        chk($sformatf("full[%0d]", g), 32'(bus.full), 32'(q.size() == 32));
        chk($sformatf("overflow[%0d]", g), 32'(bus.overflow), 32'(ovf));
      end
    end
  end

  task automatic cyc(input bit r, input bit c, input bit we,
                     input logic [7:0] d, input bit re);
    rst = r;
    clr = c;
    wr_en = we;
    wr_data = d;
    rd_en = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 8'h00, 0);
    run = 1'b1;
    cyc(1, 0, 1, 8'h99, 1);
    chk("rst rd_data", 32'(g_u[0].bus.rd_data), 0);
    chk("rst rd_valid", 32'(g_u[0].bus.rd_valid), 0);
    chk("rst empty", 32'(g_u[0].bus.empty), 1);
    chk("rst full", 32'(g_u[1].bus.full), 0);
    chk("rst count", 32'(g_u[1].bus.count), 0);
    chk("rst overflow", 32'(g_u[1].bus.overflow), 0);

    cyc(0, 0, 1, 8'h1C, 0);
    cyc(0, 0, 1, 8'h32, 0);
    cyc(0, 0, 1, 8'h21, 0);
    chk("three count", 32'(g_u[0].bus.count), 3);
    cyc(0, 0, 0, 8'h00, 1);
    chk("rd1 data", 32'(g_u[0].bus.rd_data), 32'h1C);
    chk("rd1 count", 32'(g_u[0].bus.count), 2);
    cyc(0, 0, 0, 8'h00, 1);
    chk("rd2 data", 32'(g_u[0].bus.rd_data), 32'h32);
    cyc(0, 0, 0, 8'h00, 1);
    chk("rd3 data", 32'(g_u[0].bus.rd_data), 32'h21);
    chk("rd3 valid", 32'(g_u[0].bus.rd_valid), 1);
    chk("rd3 empty", 32'(g_u[0].bus.empty), 1);

    for (int i = 0; i < 33; i++) cyc(0, 0, 1, 8'(i), 0);
    for (int g = 0; g < 2; g++) begin
      chk("ovf full", 32'(g == 0 ? g_u[0].bus.full : g_u[1].bus.full), 1);
      chk("ovf count", 32'(g == 0 ? g_u[0].bus.count : g_u[1].bus.count), 32);
      chk("ovf flag", 32'(g == 0 ? g_u[0].bus.overflow : g_u[1].bus.overflow), 1);
    end
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 8'h00, 1);
      chk("drop drain", 32'(g_u[0].bus.rd_data), i);
      chk("ovw drain", 32'(g_u[1].bus.rd_data), i + 1);
    end
    cyc(0, 0, 0, 8'h00, 1);
    chk("drained valid", 32'(g_u[0].bus.rd_valid), 0);
    chk("drained ovf sticky", 32'(g_u[0].bus.overflow), 1);

    cyc(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 8'(i + 8'h40), 0);
    cyc(0, 0, 1, 8'hAA, 1);
    chk("fullrw data", 32'(g_u[0].bus.rd_data), 32'h40);
    chk("fullrw count", 32'(g_u[0].bus.count), 32);
    chk("fullrw ovf0", 32'(g_u[0].bus.overflow), 0);
    chk("fullrw ovf1", 32'(g_u[1].bus.overflow), 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 8'h00, 1);
    chk("fullrw last", 32'(g_u[0].bus.rd_data), 32'hAA);
    chk("fullrw last1", 32'(g_u[1].bus.rd_data), 32'hAA);

    cyc(0, 0, 1, 8'h5A, 1);
    chk("emptyrw valid", 32'(g_u[0].bus.rd_valid), 0);
    chk("emptyrw count", 32'(g_u[0].bus.count), 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("emptyrw data", 32'(g_u[0].bus.rd_data), 32'h5A);
    cyc(0, 0, 0, 8'h00, 1);
    chk("empty rd valid", 32'(g_u[0].bus.rd_valid), 0);
    chk("empty rd data", 32'(g_u[0].bus.rd_data), 0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(59) == 0),
          ($urandom_range(99) < (i < 200 ? 60 : 45)), 8'($urandom),
          ($urandom_range(99) < (i < 200 ? 40 : 60)));
    end

    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 8'(i + 3), 0);
    cyc(0, 1, 1, 8'h77, 1);
    chk("clr count", 32'(g_u[0].bus.count), 0);
    chk("clr ovf", 32'(g_u[1].bus.overflow), 0);
    chk("clr valid", 32'(g_u[1].bus.rd_valid), 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("clr discard", 32'(g_u[0].bus.rd_valid), 0);
    cyc(0, 0, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
